// File: rtl/uart_cmd_engine.sv
// Command engine between uart_rx and uart_tx: parses A5/CMD/DATA/CHK frames,
// drives the LED register or samples buttons, and returns a STATUS/VALUE pair.
module uart_cmd_engine #(
    parameter int unsigned LED_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CLKS = 86800
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Rx_DV,
    input  logic [7:0]           i_Rx_Byte,
    input  logic [7:0]           i_Buttons,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    output logic [LED_WIDTH-1:0] o_Leds,
    output logic                 o_Frame_Err
);

    localparam int unsigned CntW = (TIMEOUT_CLKS < 1) ? 1 : $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CLKS);

    localparam logic [7:0] Header    = 8'hA5;
    localparam logic [7:0] CmdWrLeds = 8'h01;
    localparam logic [7:0] CmdRdBtns = 8'h02;
    localparam logic [7:0] CmdRdLeds = 8'h03;
    localparam logic [7:0] StatOk    = 8'h5A;
    localparam logic [7:0] StatErr   = 8'hEE;

    typedef enum logic [3:0] {
        StIdle,
        StGetCmd,
        StGetData,
        StGetChk,
        StExec,
        StTxStat,
        StWaitStat,
        StTxVal,
        StWaitVal
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] tmo_cnt_q;
    logic [7:0]      cmd_q;
    logic [7:0]      data_q;
    logic [7:0]      chk_q;
    logic [7:0]      status_q;
    logic [7:0]      value_q;
    logic [7:0]      btn_meta_q;
    logic [7:0]      btn_sync_q;
    logic            tmo_hit;

    assign tmo_hit = (tmo_cnt_q == CntMax);

    // Buttons are asynchronous to i_Clock.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            btn_meta_q <= 8'h00;
            btn_sync_q <= 8'h00;
        end else begin
            btn_meta_q <= i_Buttons;
            btn_sync_q <= btn_meta_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= StIdle;
            tmo_cnt_q   <= '0;
            cmd_q       <= 8'h00;
            data_q      <= 8'h00;
            chk_q       <= 8'h00;
            status_q    <= 8'h00;
            value_q     <= 8'h00;
            o_Tx_DV     <= 1'b0;
            o_Tx_Byte   <= 8'h00;
            o_Leds      <= '0;
            o_Frame_Err <= 1'b0;
        end else begin
            o_Tx_DV     <= 1'b0;
            o_Frame_Err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tmo_cnt_q <= '0;
                    if (i_Rx_DV && (i_Rx_Byte == Header)) begin
                        state_q <= StGetCmd;
                    end
                end
                StGetCmd: begin
                    if (tmo_hit) begin
                        state_q     <= StIdle;
                        o_Frame_Err <= 1'b1;
                        tmo_cnt_q   <= '0;
                    end else if (i_Rx_DV) begin
                        cmd_q     <= i_Rx_Byte;
                        tmo_cnt_q <= '0;
                        state_q   <= StGetData;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
                    end
                end
                StGetData: begin
                    if (tmo_hit) begin
                        state_q     <= StIdle;
                        o_Frame_Err <= 1'b1;
                        tmo_cnt_q   <= '0;
                    end else if (i_Rx_DV) begin
                        data_q    <= i_Rx_Byte;
                        tmo_cnt_q <= '0;
                        state_q   <= StGetChk;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
                    end
                end
                StGetChk: begin
                    if (tmo_hit) begin
                        state_q     <= StIdle;
                        o_Frame_Err <= 1'b1;
                        tmo_cnt_q   <= '0;
                    end else if (i_Rx_DV) begin
                        chk_q     <= i_Rx_Byte;
                        tmo_cnt_q <= '0;
                        state_q   <= StExec;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CntW'(1);
                    end
                end
                StExec: begin
                    state_q <= StTxStat;
                    if (chk_q != (cmd_q ^ data_q)) begin
                        status_q    <= StatErr;
                        value_q     <= 8'h00;
                        o_Frame_Err <= 1'b1;
                    end else begin
                        case (cmd_q)
                            CmdWrLeds: begin
                                o_Leds   <= data_q[LED_WIDTH-1:0];
                                status_q <= StatOk;
                                value_q  <= data_q;
                            end
                            CmdRdBtns: begin
                                status_q <= StatOk;
                                value_q  <= btn_sync_q;
                            end
                            CmdRdLeds: begin
                                status_q <= StatOk;
                                value_q  <= 8'(o_Leds);
                            end
                            default: begin
                                status_q    <= StatErr;
                                value_q     <= cmd_q;
                                o_Frame_Err <= 1'b1;
                            end
                        endcase
                    end
                end
                StTxStat: begin
                    if (!i_Tx_Active) begin
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= status_q;
                        state_q   <= StWaitStat;
                    end
                end
                StWaitStat: begin
                    if (i_Tx_Done) begin
                        state_q <= StTxVal;
                    end
                end
                StTxVal: begin
                    if (!i_Tx_Active) begin
                        o_Tx_DV   <= 1'b1;
                        o_Tx_Byte <= value_q;
                        state_q   <= StWaitVal;
                    end
                end
                StWaitVal: begin
                    if (i_Tx_Done) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
